// File: rtl/pipeline_trace_pkg.sv
// Shared types for the retire-trace buffer: FSM state encoding and the
// stored trace entry layout.
package pipeline_trace_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_ARMED = 2'd1;
  localparam logic [1:0] ENC_POST  = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    ARMED = ENC_ARMED,
    POST  = ENC_POST,
    DONE  = ENC_DONE
  } trace_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] busW;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// A same-cycle read and write to one address returns the old contents.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 96
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read data, cleared on reset so outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Retire-trace capture beside the pipelined processor. Samples {pc, instr,
// busW} into a circular buffer while armed and stops POST_TRIG samples after
// a PC-match trigger. Define TRACE_TIMESTAMP_EN to store a cycle timestamp
// with each entry and expose it on rd_ts.
module pipeline_trace_buffer
  import pipeline_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int TS_W      = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  input  logic                     valid,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic [31:0]              busW,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [31:0]              rd_busW,
  output logic                     rd_valid,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]          rd_ts,
`endif
  output logic [1:0]               state,
  output logic                     triggered,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = $bits(trace_entry_t) + TS_W;
`else
  // TS_W only shapes storage when timestamps are built in.
  localparam int ENTRY_W = $bits(trace_entry_t) + 0 * TS_W;
`endif

  trace_state_t    st, st_nxt;
  logic [AW-1:0]   wr_ptr, post_cnt, oldest, raddr;
  logic [AW:0]     cnt;
  logic            wr_en, trig_hit, post_last;
  trace_entry_t    ent;
  logic [ENTRY_W-1:0] wdata, rdata;

  // arm always wins over a same-cycle sample
  assign wr_en     = valid && !arm && (st == ARMED || st == POST);
  assign trig_hit  = wr_en && (st == ARMED) && (pc == trig_pc);
  assign post_last = wr_en && (st == POST) && (post_cnt == AW'(1));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next-state logic; re-arm from any state restarts capture.
  always_comb begin
    st_nxt = st;
    if (arm) st_nxt = ARMED;
    else begin
      case (st)
        ARMED:   if (trig_hit)  st_nxt = (POST_TRIG == 0) ? DONE : POST;
        POST:    if (post_last) st_nxt = DONE;
        default: ;
      endcase
    end
  end

  // Write pointer, fill count, post-trigger countdown and trigger flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0; cnt <= '0; post_cnt <= '0; triggered <= 1'b0;
    end else if (arm) begin
      wr_ptr <= '0; cnt <= '0; post_cnt <= '0; triggered <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (cnt != FULL) cnt <= cnt + 1'b1;
      if (trig_hit) begin
        triggered <= 1'b1;
        post_cnt  <= AW'(POST_TRIG);
      end else if (st == POST) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

  // Read request valid: one pulse per request, matching the RAM read latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  // rd_addr 0 maps to the oldest entry; once full that is the next write slot.
  assign oldest = (cnt == FULL) ? wr_ptr : '0;
  assign raddr  = oldest + rd_addr;
  assign ent    = '{pc: pc, instr: instr, busW: busW};

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running cycle stamp, restarted by arm.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   ts <= '0;
    else if (arm) ts <= '0;
    else          ts <= ts + 1'b1;
  end

  assign wdata = {ts, ent};
  assign {rd_ts, rd_pc, rd_instr, rd_busW} = rdata;
`else
  assign wdata = ent;
  assign {rd_pc, rd_instr, rd_busW} = rdata;
`endif

  trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
    .clk(CLK), .rst_n(RST_N),
    .we(wr_en), .waddr(wr_ptr), .wdata(wdata),
    .re(rd_en), .raddr(raddr), .rdata(rdata)
  );

  assign state = st;
  assign done  = (st == DONE);
  assign count = cnt;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed bench for pipeline_trace_buffer. Two instances share stimulus:
// u0 with POST_TRIG=8, u1 with POST_TRIG=0. Sample data is instr=pc^DEAD0000,
// busW=pc+0x1000.
module tb_pipeline_trace_buffer;

  logic        CLK, RST_N, arm, valid, rd_en;
  logic [31:0] trig_pc, pc, instr, busW;
  logic [3:0]  rd_addr;
  logic [31:0] rd_pc0, rd_instr0, rd_busW0, rd_pc1, rd_instr1, rd_busW1;
  logic        rd_valid0, rd_valid1, trig0, trig1, done0, done1;
  logic [1:0]  state0, state1;
  logic [4:0]  count0, count1;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts0, ts1;
`endif
  int errors = 0;
  int checks = 0;

  pipeline_trace_buffer #(.DEPTH(16), .POST_TRIG(8), .TS_W(16)) u0 (
    .CLK(CLK), .RST_N(RST_N), .arm(arm), .trig_pc(trig_pc), .valid(valid),
    .pc(pc), .instr(instr), .busW(busW), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_busW(rd_busW0), .rd_valid(rd_valid0),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(ts0),
`endif
    .state(state0), .triggered(trig0), .done(done0), .count(count0));

  pipeline_trace_buffer #(.DEPTH(16), .POST_TRIG(0), .TS_W(16)) u1 (
    .CLK(CLK), .RST_N(RST_N), .arm(arm), .trig_pc(trig_pc), .valid(valid),
    .pc(pc), .instr(instr), .busW(busW), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pc(rd_pc1), .rd_instr(rd_instr1), .rd_busW(rd_busW1), .rd_valid(rd_valid1),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(ts1),
`endif
    .state(state1), .triggered(trig1), .done(done1), .count(count1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic pulse_arm;
    arm = 1'b1; tick; arm = 1'b0;
  endtask

  task automatic samp(input logic [31:0] p);
    valid = 1'b1; pc = p; instr = p ^ 32'hDEAD_0000; busW = p + 32'h1000;
    tick; valid = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_addr = a[3:0]; rd_en = 1'b1; tick; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; tick; tick;
    checks++; if (state0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state0); end
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", done0); end
    checks++; if (rd_pc0 !== 32'h0) begin errors++; $display("FAIL reset_rd_pc got %h want 0", rd_pc0); end
    RST_N = 1'b1; tick;
    trig_pc = 32'hFFFF_FFFC;
    pulse_arm; samp(32'h0); samp(32'h4); samp(32'h8);
    rd_addr = 4'd1; rd_en = 1'b1; tick;
    checks++; if (rd_valid0 !== 1'b1) begin errors++; $display("FAIL pre_reset_rd_valid got %0d want 1", rd_valid0); end
    checks++; if (rd_pc0 !== 32'h4) begin errors++; $display("FAIL pre_reset_rd_pc got %h want 4", rd_pc0); end
    checks++; if (count0 !== 5'd3) begin errors++; $display("FAIL pre_reset_count got %0d want 3", count0); end
    // mid-cycle reset, observed before any clock edge
    #2 RST_N = 1'b0; #1;
    checks++; if (state0 !== 2'd0) begin errors++; $display("FAIL async_state got %0d want 0", state0); end
    checks++; if (count0 !== 5'd0) begin errors++; $display("FAIL async_count got %0d want 0", count0); end
    checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL async_rd_valid got %0d want 0", rd_valid0); end
    checks++; if (rd_pc0 !== 32'h0) begin errors++; $display("FAIL async_rd_pc got %h want 0", rd_pc0); end
    rd_en = 1'b0;
    @(negedge CLK); RST_N = 1'b1; tick;
  endtask

  task automatic test_wrap;
    trig_pc = 32'hFFFF_FFFC;
    pulse_arm;
    for (int k = 0; k < 20; k++) samp(32'(k * 4));
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL wrap_count got %0d want 16", count0); end
    checks++; if (state0 !== 2'd1) begin errors++; $display("FAIL wrap_state got %0d want 1", state0); end
    checks++; if (trig0 !== 1'b0) begin errors++; $display("FAIL wrap_triggered got %0d want 0", trig0); end
    // back-to-back reads
    rd_addr = 4'd0; rd_en = 1'b1; tick;
    checks++; if (rd_valid0 !== 1'b1) begin errors++; $display("FAIL wrap_rd_valid0 got %0d want 1", rd_valid0); end
    checks++; if (rd_pc0 !== 32'd16) begin errors++; $display("FAIL wrap_oldest_pc got %0d want 16", rd_pc0); end
    checks++; if (rd_instr0 !== 32'hDEAD_0010) begin errors++; $display("FAIL wrap_oldest_instr got %h want dead0010", rd_instr0); end
    checks++; if (rd_busW0 !== 32'h0000_1010) begin errors++; $display("FAIL wrap_oldest_busW got %h want 00001010", rd_busW0); end
    rd_addr = 4'd15; tick; rd_en = 1'b0;
    checks++; if (rd_valid0 !== 1'b1) begin errors++; $display("FAIL wrap_rd_valid1 got %0d want 1", rd_valid0); end
    checks++; if (rd_pc0 !== 32'd76) begin errors++; $display("FAIL wrap_newest_pc got %0d want 76", rd_pc0); end
    tick;
    checks++; if (rd_valid0 !== 1'b0) begin errors++; $display("FAIL wrap_rd_valid_pulse got %0d want 0", rd_valid0); end
  endtask

  task automatic test_trigger;
    trig_pc = 32'h28;
    pulse_arm;
    for (int k = 0; k < 19; k++) begin
      samp(32'(k * 4));
      if (k == 9) begin
        checks++; if (trig0 !== 1'b0) begin errors++; $display("FAIL trig_early got %0d want 0", trig0); end
      end
      if (k == 10) begin
        checks++; if (trig0 !== 1'b1) begin errors++; $display("FAIL trig_flag got %0d want 1", trig0); end
        checks++; if (state0 !== 2'd2) begin errors++; $display("FAIL trig_state got %0d want 2", state0); end
      end
      if (k == 17) begin
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL trig_done_early got %0d want 0", done0); end
      end
    end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL trig_done got %0d want 1", done0); end
    checks++; if (state0 !== 2'd3) begin errors++; $display("FAIL trig_state_done got %0d want 3", state0); end
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL trig_count got %0d want 16", count0); end
    samp(32'h4C);
    checks++; if (count0 !== 5'd16) begin errors++; $display("FAIL trig_frozen_count got %0d want 16", count0); end
    rd(0);
    checks++; if (rd_pc0 !== 32'h0C) begin errors++; $display("FAIL trig_oldest_pc got %h want c", rd_pc0); end
    rd(15);
    checks++; if (rd_pc0 !== 32'h48) begin errors++; $display("FAIL trig_newest_pc got %h want 48", rd_pc0); end
  endtask

  task automatic test_trig_last;
    trig_pc = 32'h8;
    pulse_arm;
    samp(32'h0); samp(32'h4); samp(32'h8);
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL last_done got %0d want 1", done1); end
    checks++; if (trig1 !== 1'b1) begin errors++; $display("FAIL last_triggered got %0d want 1", trig1); end
    samp(32'hC);
    checks++; if (count1 !== 5'd3) begin errors++; $display("FAIL last_count got %0d want 3", count1); end
    checks++; if (state1 !== 2'd3) begin errors++; $display("FAIL last_state got %0d want 3", state1); end
    rd(2);
    checks++; if (rd_pc1 !== 32'h8) begin errors++; $display("FAIL last_rd_pc got %h want 8", rd_pc1); end
  endtask

  task automatic test_collision;
    arm = 1'b1; valid = 1'b1; pc = 32'h0; instr = 32'hDEAD_0000; busW = 32'h1000;
    tick; arm = 1'b0; valid = 1'b0;
    checks++; if (state1 !== 2'd1) begin errors++; $display("FAIL coll_state got %0d want 1", state1); end
    checks++; if (count1 !== 5'd0) begin errors++; $display("FAIL coll_count got %0d want 0", count1); end
    checks++; if (trig1 !== 1'b0) begin errors++; $display("FAIL coll_triggered got %0d want 0", trig1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL coll_done got %0d want 0", done1); end
    tick;
    checks++; if (count1 !== 5'd0) begin errors++; $display("FAIL coll_count_hold got %0d want 0", count1); end
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp;
    trig_pc = 32'hFFFF_FFFC;
    pulse_arm;
    tick; tick; tick;
    samp(32'h100);
    tick;
    samp(32'h104);
    rd(0);
    checks++; if (ts0 !== 16'd3) begin errors++; $display("FAIL ts_first got %0d want 3", ts0); end
    checks++; if (rd_valid0 !== 1'b1) begin errors++; $display("FAIL ts_rd_valid got %0d want 1", rd_valid0); end
    rd(1);
    checks++; if (ts0 !== 16'd5) begin errors++; $display("FAIL ts_second got %0d want 5", ts0); end
    checks++; if (rd_pc0 !== 32'h104) begin errors++; $display("FAIL ts_rd_pc got %h want 104", rd_pc0); end
  endtask
`endif

  initial begin
    RST_N = 1'b0; arm = 1'b0; valid = 1'b0; rd_en = 1'b0; rd_addr = 4'd0;
    trig_pc = 32'h0; pc = 32'h0; instr = 32'h0; busW = 32'h0;
    test_reset;
    test_wrap;
    test_trigger;
    test_trig_last;
    test_collision;
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
